serial_addsub: RTL and testbench



---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_cell.sv | 20 ++
 rtl/serial_addsub.sv | 142 ++++++++++++++
 tb/tb_serial_addsub.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared encodings for the bit-serial add/subtract unit.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_cell.sv
// One-bit full adder / full subtractor; cout is carry for add, borrow for subtract.
module addsub_cell
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);

  logic a_eff;

  // Borrow generation is the carry majority function with the minuend inverted.
  assign a_eff = (op == OP_SUB) ? ~a : a;
  assign s     = a ^ b ^ cin;
  assign cout  = (a_eff & b) | (b & cin) | (a_eff & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one cell iterated LSB-first over WIDTH cycles,
// with a start/busy/done handshake and registered result and flags.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last completed result
//   RUN   | one operand bit per cycle through the cell (busy=1)
//   DONE  | one-cycle done pulse; start here chains straight into RUN
module serial_addsub
  import addsub_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_bout,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   r_sr_q, r_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               cb_q, cb_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_bout_q, cout_bout_d;
  logic               ovf_q, ovf_d;

  logic               cell_s;
  logic               cell_cout;
  logic               last_bit;

  addsub_cell u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (cb_q),
    .op   (op_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    r_sr_d      = r_sr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    cb_d        = cb_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    result_d    = result_q;
    cout_bout_d = cout_bout_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          op_d    = op;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          r_sr_d  = '0;
          cnt_d   = '0;
          cb_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = {cell_s, r_sr_q[WIDTH-1:1]};
        cb_d   = cell_cout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // The bit produced now is the result MSB, so flags resolve this cycle.
          cnt_d       = '0;
          result_d    = {cell_s, r_sr_q[WIDTH-1:1]};
          cout_bout_d = cell_cout;
          if (op_q == OP_SUB)
            ovf_d = (a_msb_q != b_msb_q) && (cell_s != a_msb_q);
          else
            ovf_d = (a_msb_q == b_msb_q) && (cell_s != a_msb_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      r_sr_q      <= '0;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      cb_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      result_q    <= '0;
      cout_bout_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      r_sr_q      <= r_sr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      cb_q        <= cb_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      result_q    <= result_d;
      cout_bout_q <= cout_bout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign cout_bout = cout_bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub and its addsub_cell: directed and random operations
// compared against an integer-arithmetic reference model.
module tb_serial_addsub;
  import addsub_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout_bout, ovf;
  logic [W-1:0] result;

  logic c_a = 1'b0, c_b = 1'b0, c_cin = 1'b0, c_op = 1'b0;
  logic c_s, c_cout;

  int           nchk = 0;
  int           nerr = 0;
  logic [W-1:0] prev_res = '0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout_bout (cout_bout),
    .ovf       (ovf)
  );

  addsub_cell u_cell (
    .a    (c_a),
    .b    (c_b),
    .cin  (c_cin),
    .op   (c_op),
    .s    (c_s),
    .cout (c_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] r, output logic c, output logic v);
    int md, ua, ub, sa, sb, u, s;
    md = 1 << W;
    ua = int'(av);
    ub = int'(bv);
    sa = av[W-1] ? ua - md : ua;
    sb = bv[W-1] ? ub - md : ub;
    if (o == OP_SUB) begin
      u = ua - ub;
      s = sa - sb;
      c = (ua < ub);
    end else begin
      u = ua + ub;
      s = sa + sb;
      c = (u >= md);
    end
    r = W'((u + md) % md);
    v = (s > md / 2 - 1) || (s < -(md / 2));
  endtask

  task automatic start_pulse(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    op    = 1'($urandom);
  endtask

  // Entered on the first busy cycle; leaves one cycle after done, or on the
  // first busy cycle of a chained operation when chain is set.
  task automatic finish_op(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input string tag, input bit disturb, input bit chain,
                           input logic co, input logic [W-1:0] ca, input logic [W-1:0] cb);
    logic [W-1:0] er;
    logic         ec, ev;
    int           busy_cnt;
    bit           seen;
    model(o, av, bv, er, ec, ev);
    busy_cnt = 0;
    seen     = 0;
    for (int i = 0; i < W + 4 && !seen; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) begin
          busy_cnt++;
          check({tag, "_held_in_run"}, 32'(result), 32'(prev_res));
          if (disturb) begin
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            op    = 1'($urandom);
          end
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, "_busy_in_done"}, 32'(busy), 32'(0));
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout_bout"}, 32'(cout_bout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(ev));
    prev_res = er;
    if (chain) begin
      op    = co;
      a     = ca;
      b     = cb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end else begin
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'(0));
      check({tag, "_result_hold"}, 32'(result), 32'(er));
    end
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input string tag);
    start_pulse(o, av, bv);
    finish_op(o, av, bv, tag, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic         ro;
    logic [W-1:0] ra, rb;
    int           t, done_cnt;

    for (int i = 0; i < 16; i++) begin
      {c_op, c_a, c_b, c_cin} = 4'(i);
      #1;
      if (c_op == OP_SUB) t = int'(c_a) - int'(c_b) - int'(c_cin);
      else                t = int'(c_a) + int'(c_b) + int'(c_cin);
      check("cell_s", 32'(c_s), 32'(t & 1));
      check("cell_cout", 32'(c_cout), c_op ? 32'(t < 0) : 32'(t > 1));
    end

    // start asserted while reset is held must not launch anything
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_cout_bout", 32'(cout_bout), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_done", 32'(done), 32'(0));

    run_op(OP_SUB, 4'd5, 4'd3, "sub_5_3");
    run_op(OP_SUB, 4'd3, 4'd5, "sub_3_5");
    run_op(OP_SUB, 4'h8, 4'd1, "sub_8_1");
    run_op(OP_ADD, 4'd9, 4'd8, "add_9_8");
    run_op(OP_ADD, 4'd7, 4'd1, "add_7_1");

    start_pulse(OP_ADD, 4'd2, 4'd3);
    finish_op(OP_ADD, 4'd2, 4'd3, "disturb", 1'b1, 1'b0, 1'b0, '0, '0);

    start_pulse(OP_SUB, 4'hC, 4'd5);
    finish_op(OP_SUB, 4'hC, 4'd5, "b2b_first", 1'b0, 1'b1, OP_SUB, 4'd6, 4'd6);
    check("b2b_busy_immediate", 32'(busy), 32'(1));
    finish_op(OP_SUB, 4'd6, 4'd6, "b2b_second", 1'b0, 1'b0, 1'b0, '0, '0);

    for (int k = 0; k < 20; k++) begin
      ro = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ro, ra, rb, "rand");
    end

    run_op(OP_ADD, 4'd9, 4'd8, "pre_reset");
    start_pulse(OP_ADD, 4'd3, 4'd4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_result", 32'(result), 32'(0));
    check("midrst_cout_bout", 32'(cout_bout), 32'(0));
    check("midrst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'(0));
    check("midrst_idle_busy", 32'(busy), 32'(0));
    prev_res = '0;
    run_op(OP_SUB, 4'hA, 4'd3, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
